// File: rtl/age_matrix_select.sv
// Oldest-first issue select using a DEPTH x DEPTH age matrix, with a
// registered valid/ready grant, entry valid bits and occupancy.
// Ports: clk, rst_n (async low), flush, alloc_valid/alloc_idx, ready,
// op_flat (only with AGE_SEL_OP_FILTER_EN), issue_valid/issue_idx/
// issue_ready, occupancy, full, alloc_err.
// Optional macro: AGE_SEL_OP_FILTER_EN restricts grants to opcode OP.

`ifndef R_TYPE
`define R_TYPE 7'b0110011
`endif

module age_matrix_select #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int OPCODE_WIDTH = 7,
  parameter logic [OPCODE_WIDTH-1:0] OP = `R_TYPE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          alloc_valid,
  input  logic [IDX_W-1:0]              alloc_idx,
  input  logic [DEPTH-1:0]              ready,
`ifdef AGE_SEL_OP_FILTER_EN
  input  logic [DEPTH*OPCODE_WIDTH-1:0] op_flat,
`endif
  output logic                          issue_valid,
  output logic [IDX_W-1:0]              issue_idx,
  input  logic                          issue_ready,
  output logic [IDX_W:0]                occupancy,
  output logic                          full,
  output logic                          alloc_err
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] inflight_q;
  logic [DEPTH-1:0] older_q [DEPTH];

  logic [DEPTH-1:0] op_ok;
  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] blocked;
  logic [DEPTH-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic             hs;
  logic             load;
  logic             alloc_ok;
  logic             alloc_bad;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] inflight_d;
  logic [IDX_W:0]   occ_d;

`ifdef AGE_SEL_OP_FILTER_EN
  always_comb begin
    op_ok = '0;
    for (int i = 0; i < DEPTH; i++) begin
      op_ok[i] = (op_flat[i*OPCODE_WIDTH +: OPCODE_WIDTH] == OP);
    end
  end
`else
  logic unused_op;
  assign unused_op = ^OP;
  assign op_ok = '1;
`endif

  assign req = valid_q & ready & ~inflight_q & op_ok;

  // An entry is blocked if any other requester is older than it.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        blocked[i] = blocked[i] | (req[j] & older_q[j][i]);
      end
    end
  end

  assign win = req & ~blocked;
  assign any_req = |req;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (win[i]) win_idx = IDX_W'(i);
    end
  end

  assign hs = issue_valid & issue_ready;
  assign load = !issue_valid || hs;
  assign alloc_ok = alloc_valid && !flush && !valid_q[alloc_idx];
  assign alloc_bad = alloc_valid && !flush && valid_q[alloc_idx];

  always_comb begin
    valid_d = valid_q;
    inflight_d = inflight_q;
    occ_d = occupancy;
    if (hs) begin
      valid_d[issue_idx] = 1'b0;
      inflight_d[issue_idx] = 1'b0;
    end
    if (alloc_ok) valid_d[alloc_idx] = 1'b1;
    if (load && any_req) inflight_d[win_idx] = 1'b1;
    unique case ({alloc_ok, hs})
      2'b10:   occ_d = occupancy + 1'b1;
      2'b01:   occ_d = occupancy - 1'b1;
      default: occ_d = occupancy;
    endcase
    if (flush) begin
      valid_d = '0;
      inflight_d = '0;
      occ_d = '0;
    end
  end

  assign full = (occupancy == (IDX_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      inflight_q <= '0;
      issue_valid <= 1'b0;
      issue_idx <= '0;
      occupancy <= '0;
      alloc_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      inflight_q <= inflight_d;
      occupancy <= occ_d;
      alloc_err <= alloc_bad;
      if (flush) begin
        issue_valid <= 1'b0;
      end else if (load) begin
        issue_valid <= any_req;
        if (any_req) issue_idx <= win_idx;
      end
      // New entry is youngest: clear its row, mark every live entry older.
      // Stale state of freed entries is overwritten on their next alloc.
      if (alloc_ok) begin
        older_q[alloc_idx] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (valid_q[j]) older_q[j][alloc_idx] <= 1'b1;
        end
      end
    end
  end

endmodule
